// File: rtl/approx_mult_bist.sv
// approx_mult_bist: LFSR operand generator and error-statistics checker for approximate multipliers
module approx_mult_bist #(
  parameter int SW      = 24,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 20,
  parameter int ACC_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_samples_i,
  input  logic [31:0]       seed_i,
  output logic [SW-1:0]     Data_A_o,
  output logic [SW-1:0]     Data_B_o,
  output logic              load_b_o,
  input  logic [2*SW-1:0]   sgf_result_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sample_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [2*SW-1:0]   err_max_o,
  output logic [ACC_W-1:0]  err_sum_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [LATENCY-1:0] LAST_V = LATENCY'(1) << (LATENCY - 1);
  state_t             r_state;
  logic [31:0]        r_lfsr_a, r_lfsr_b;
  logic [CNT_W-1:0]   r_rem;
  logic [LATENCY-1:0] r_vld;
  logic [SW-1:0]      r_da [LATENCY];
  logic [SW-1:0]      r_db [LATENCY];
  logic [31:0]        w_seed_a, w_rot, w_seed_b;
  logic [2*SW-1:0]    w_exact, w_err;
  logic [ACC_W:0]     w_sum_ext;
  logic [ACC_W-1:0]   w_sum_next;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  // a zero seed is treated as seed 1 for both generators, so seed 0 and seed 1 runs coincide
  assign w_seed_a   = (seed_i == 32'h0) ? 32'h1 : seed_i;
  assign w_rot      = {w_seed_a[15:0], w_seed_a[31:16]} ^ 32'hA5A5_A5A5;
  assign w_seed_b   = (w_rot == 32'h0) ? 32'h1 : w_rot;
  assign w_exact    = (2*SW)'(r_da[LATENCY-1]) * (2*SW)'(r_db[LATENCY-1]);
  assign w_err      = (sgf_result_i >= w_exact) ? sgf_result_i - w_exact : w_exact - sgf_result_i;
  assign w_sum_ext  = {1'b0, err_sum_o} + (ACC_W+1)'(w_err);
  assign w_sum_next = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign busy_o     = (r_state == RUN) || (r_state == DRAIN);
  assign done_o     = (r_state == DONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lfsr_a     <= '0;
      r_lfsr_b     <= '0;
      r_rem        <= '0;
      r_vld        <= '0;
      r_da         <= '{default: '0};
      r_db         <= '{default: '0};
      Data_A_o     <= '0;
      Data_B_o     <= '0;
      load_b_o     <= 1'b0;
      sample_cnt_o <= '0;
      err_cnt_o    <= '0;
      err_max_o    <= '0;
      err_sum_o    <= '0;
    end else begin
      r_vld[0] <= load_b_o;
      r_da[0]  <= Data_A_o;
      r_db[0]  <= Data_B_o;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_da[i]  <= r_da[i-1];
        r_db[i]  <= r_db[i-1];
      end
      if (r_vld[LATENCY-1]) begin
        sample_cnt_o <= sample_cnt_o + 1'b1;
        err_cnt_o    <= err_cnt_o + CNT_W'(w_err != '0);
        err_max_o    <= (w_err > err_max_o) ? w_err : err_max_o;
        err_sum_o    <= w_sum_next;
      end
      case (r_state)
        IDLE, DONE: if (start_i) begin
          sample_cnt_o <= '0;
          err_cnt_o    <= '0;
          err_max_o    <= '0;
          err_sum_o    <= '0;
          if (num_samples_i == '0) r_state <= DONE;
          else begin
            // the first pair is issued straight from the seeds on the accepting edge
            r_state  <= RUN;
            load_b_o <= 1'b1;
            Data_A_o <= w_seed_a[SW-1:0];
            Data_B_o <= w_seed_b[SW-1:0];
            r_lfsr_a <= lfsr_step(w_seed_a);
            r_lfsr_b <= lfsr_step(w_seed_b);
            r_rem    <= num_samples_i - 1'b1;
          end
        end
        RUN: if (r_rem != '0) begin
          load_b_o <= 1'b1;
          Data_A_o <= r_lfsr_a[SW-1:0];
          Data_B_o <= r_lfsr_b[SW-1:0];
          r_lfsr_a <= lfsr_step(r_lfsr_a);
          r_lfsr_b <= lfsr_step(r_lfsr_b);
          r_rem    <= r_rem - 1'b1;
        end else begin
          load_b_o <= 1'b0;
          r_state  <= DRAIN;
        end
        DRAIN: if (r_vld == LAST_V) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
